qnet_qtp_rx: RTL and testbench

Receive end of the QNET QTP link. Takes a 32-bit AXI-Stream of QTP packets, assembles and checks the 96-bit QTP_CTRL header, and passes accepted payload words out on a registered AXI-Stream. Each packet is a 3-word header followed by qtp_len payload words. It sits between the link deserializer and the port/memory write logic that consumes PORT_DT data. Bad packets are dropped and counted.

---
 rtl/qnet_qtp_rx.sv | 176 +++++++++++++++++
 tb/tb_qnet_qtp_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qnet_qtp_rx.sv
// QTP link receiver: parses the 3-word QTP_CTRL header, filters by version/destination and forwards payload words.
// Latency: header 1 clk after word2, payload 1 clk (one-entry output register); input stalls only while that register is full and not draining.
module qnet_qtp_rx #(
    parameter logic [7:0] LOCAL_ID = 8'h01,
    parameter logic [7:0] BCAST_ID = 8'hFF,
    parameter logic [7:0] QTP_VER  = 8'h01
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [95:0] hdr_o,
    output logic        hdr_vld_o,
    output logic        err_hdr_o,
    output logic        err_short_o,
    output logic        err_long_o,
    output logic [15:0] pkt_cnt_o,
    output logic [15:0] drop_cnt_o
);

    typedef struct packed {
        logic [47:0] qtp_time;
        logic [7:0]  qtp_version;
        logic [7:0]  qtp_cfg;
        logic [7:0]  qtp_ctrl;
        logic [7:0]  qtp_dst;
        logic [15:0] qtp_len;
    } hdr_t;

    typedef enum logic [2:0] {HDR0, HDR1, HDR2, PAYLOAD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] w0_q, w1_q;
    logic [15:0] len_q, cnt_q, cnt_inc;
    hdr_t        hdr_nxt;
    logic        in_hs, good, pay_end;
    logic        ld_w0, ld_w1, ld_hdr, ld_pay, pay_last, clr_cnt;
    logic        pkt_inc, drop_inc, err_hdr_d, err_short_d, err_long_d;

    always_comb begin
        state_d     = state_q;
        ld_w0       = 1'b0;
        ld_w1       = 1'b0;
        ld_hdr      = 1'b0;
        ld_pay      = 1'b0;
        pay_last    = 1'b0;
        clr_cnt     = 1'b0;
        pkt_inc     = 1'b0;
        drop_inc    = 1'b0;
        err_hdr_d   = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        hdr_nxt     = {w0_q, w1_q, s_axis_tdata};
        good        = (hdr_nxt.qtp_version == QTP_VER) &&
                      ((hdr_nxt.qtp_dst == LOCAL_ID) || (hdr_nxt.qtp_dst == BCAST_ID));
        cnt_inc     = cnt_q + 16'd1;
        pay_end     = (cnt_inc == len_q);

        // Reset holds the link stalled; only PAYLOAD depends on the output register.
        if (rst_i)
            s_axis_tready = 1'b0;
        else if (state_q == PAYLOAD)
            s_axis_tready = !m_axis_tvalid || m_axis_tready;
        else
            s_axis_tready = 1'b1;
        in_hs = s_axis_tvalid && s_axis_tready;

        if (in_hs) begin
            case (state_q)
                HDR0, HDR1: begin
                    if (s_axis_tlast) begin
                        err_hdr_d = 1'b1;
                        drop_inc  = 1'b1;
                        state_d   = HDR0;
                    end else begin
                        ld_w0   = (state_q == HDR0);
                        ld_w1   = (state_q == HDR1);
                        state_d = (state_q == HDR0) ? HDR1 : HDR2;
                    end
                end
                HDR2: begin
                    if (good) begin
                        ld_hdr  = 1'b1;
                        pkt_inc = 1'b1;
                        if (hdr_nxt.qtp_len == 16'd0) begin
                            err_long_d = !s_axis_tlast;
                            state_d    = s_axis_tlast ? HDR0 : DROP;
                        end else if (s_axis_tlast) begin
                            err_short_d = 1'b1;
                            state_d     = HDR0;
                        end else begin
                            clr_cnt = 1'b1;
                            state_d = PAYLOAD;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = s_axis_tlast ? HDR0 : DROP;
                    end
                end
                PAYLOAD: begin
                    ld_pay   = 1'b1;
                    pay_last = pay_end || s_axis_tlast;
                    if (s_axis_tlast && !pay_end) begin
                        err_short_d = 1'b1;
                        state_d     = HDR0;
                    end else if (pay_end) begin
                        err_long_d = !s_axis_tlast;
                        state_d    = s_axis_tlast ? HDR0 : DROP;
                    end
                end
                DROP: begin
                    if (s_axis_tlast)
                        state_d = HDR0;
                end
                default: state_d = HDR0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= HDR0;
            w0_q          <= '0;
            w1_q          <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            hdr_o         <= '0;
            hdr_vld_o     <= 1'b0;
            err_hdr_o     <= 1'b0;
            err_short_o   <= 1'b0;
            err_long_o    <= 1'b0;
            pkt_cnt_o     <= '0;
            drop_cnt_o    <= '0;
        end else begin
            state_q     <= state_d;
            hdr_vld_o   <= ld_hdr;
            err_hdr_o   <= err_hdr_d;
            err_short_o <= err_short_d;
            err_long_o  <= err_long_d;
            if (ld_w0)
                w0_q <= s_axis_tdata;
            if (ld_w1)
                w1_q <= s_axis_tdata;
            if (ld_hdr) begin
                hdr_o <= hdr_nxt;
                len_q <= hdr_nxt.qtp_len;
            end
            if (clr_cnt)
                cnt_q <= '0;
            else if (ld_pay)
                cnt_q <= cnt_inc;
            // Output register drains on its own, independent of parser state.
            if (ld_pay) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= pay_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (pkt_inc && pkt_cnt_o != 16'hFFFF)
                pkt_cnt_o <= pkt_cnt_o + 16'd1;
            if (drop_inc && drop_cnt_o != 16'hFFFF)
                drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_qnet_qtp_rx.sv
// Scoreboard bench for qnet_qtp_rx: expected payload beats and headers are queued when driven, compared when produced.
module tb_qnet_qtp_rx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [95:0] hdr_o;
    logic        hdr_vld_o;
    logic        err_hdr_o;
    logic        err_short_o;
    logic        err_long_o;
    logic [15:0] pkt_cnt_o;
    logic [15:0] drop_cnt_o;

    qnet_qtp_rx dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .hdr_o(hdr_o), .hdr_vld_o(hdr_vld_o),
        .err_hdr_o(err_hdr_o), .err_short_o(err_short_o), .err_long_o(err_long_o),
        .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [32:0] exp_q[$];
    logic [95:0] hdr_q[$];
    int n_hdr = 0, n_short = 0, n_long = 0;
    int exp_hdr = 0, exp_short = 0, exp_long = 0, exp_pkt = 0, exp_drop = 0;
    int rdy_mode = 0;
    bit bp_chk = 0;
    int beat_first = -1, beat_last = -1;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Downstream ready: 0 = always ready, 1 = pattern 1,0,0,..., 2 = never ready
    initial begin
        int ph = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            ph++;
            case (rdy_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = (ph % 3 == 0);
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    always @(negedge clk_i) begin : monitor
        logic [32:0] e;
        logic [95:0] h;
        if (!rst_i) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_beat", {m_axis_tlast, m_axis_tdata}, e);
                end
                if (beat_first < 0) beat_first = cyc;
                beat_last = cyc;
            end
            if (hdr_vld_o) begin
                if (hdr_q.size() == 0) chk("hdr_unexpected", 1, 0);
                else begin
                    h = hdr_q.pop_front();
                    chk("hdr_val", hdr_o, h);
                end
            end
            if (err_hdr_o)   n_hdr++;
            if (err_short_o) n_short++;
            if (err_long_o)  n_long++;
            if (bp_chk && m_axis_tvalid && !m_axis_tready)
                chk("rdy_while_full", s_axis_tready, 0);
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l);
        bit hs;
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge clk_i);
            hs = s_axis_tready;
            @(posedge clk_i);
            #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) chk("in_timeout", 0, 1);
    endtask

    // hdr_last: -1 full header, otherwise tlast on that header word (packet ends there)
    task automatic send_pkt(input logic [47:0] t, input logic [7:0] ver, input logic [7:0] dst,
                            input logic [15:0] len, input int npay, input int hdr_last,
                            input logic [31:0] base);
        logic [31:0] w[3];
        logic [31:0] d;
        bit good;
        w[0] = t[47:16];
        w[1] = {t[15:0], ver, 8'h00};
        w[2] = {8'h07, dst, len};
        good = (hdr_last < 0) && (ver == 8'h01) && (dst == 8'h01 || dst == 8'hFF);
        if (hdr_last >= 0) begin
            exp_hdr++;
            exp_drop++;
        end else if (good) begin
            exp_pkt++;
            hdr_q.push_back({w[0], w[1], w[2]});
            if (len == 0) begin
                if (npay > 0) exp_long++;
            end else if (npay < len) exp_short++;
            else if (npay > len) exp_long++;
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < 3; i++) begin
            if (hdr_last >= 0 && i > hdr_last) break;
            send_word(w[i], (i == hdr_last) || (hdr_last < 0 && i == 2 && npay == 0));
        end
        if (hdr_last < 0)
            for (int p = 1; p <= npay; p++) begin
                d = base + p;
                if (good && p <= len)
                    exp_q.push_back({(p == len) || (p == npay), d});
                send_word(d, p == npay);
            end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        repeat (3) @(posedge clk_i);
        #1;
        chk({tag, "_outq"}, exp_q.size(), 0);
        chk({tag, "_hdrq"}, hdr_q.size(), 0);
        chk({tag, "_pkt"}, pkt_cnt_o, exp_pkt);
        chk({tag, "_drop"}, drop_cnt_o, exp_drop);
        chk({tag, "_ehdr"}, n_hdr, exp_hdr);
        chk({tag, "_eshort"}, n_short, exp_short);
        chk({tag, "_elong"}, n_long, exp_long);
        exp_q.delete();
        hdr_q.delete();
    endtask

    initial begin
        rst_i = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tready", s_axis_tready, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mvld", m_axis_tvalid, 0);
        chk("rst_hdr", hdr_o, 0);
        chk("rst_pkt", pkt_cnt_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("idle_tready", s_axis_tready, 1);
        @(posedge clk_i);
        #1;

        // good unicast, no bubbles
        beat_first = -1;
        send_pkt(48'h0000_1234_5678, 8'h01, 8'h01, 16'd3, 3, -1, 32'h9);
        drain("unicast");
        chk("unicast_nobubble", beat_last - beat_first, 2);

        // broadcast accepted, dst/version mismatches dropped
        send_pkt(48'h1111_2222_3333, 8'h01, 8'hFF, 16'd2, 2, -1, 32'h100);
        send_pkt(48'h4444_5555_6666, 8'h01, 8'h05, 16'd2, 2, -1, 32'h200);
        send_pkt(48'h7777_8888_9999, 8'h02, 8'h01, 16'd2, 2, -1, 32'h300);
        drain("filter");

        // backpressure on the output
        rdy_mode = 1;
        bp_chk = 1;
        send_pkt(48'hAAAA_BBBB_CCCC, 8'h01, 8'h01, 16'd4, 4, -1, 32'h400);
        bp_chk = 0;
        drain("backpressure");
        rdy_mode = 0;

        // short then long packets, each followed by a good one
        send_pkt(48'h0000_0000_0001, 8'h01, 8'h01, 16'd4, 2, -1, 32'h500);
        send_pkt(48'h0000_0000_0002, 8'h01, 8'h01, 16'd2, 2, -1, 32'h600);
        send_pkt(48'h0000_0000_0003, 8'h01, 8'h01, 16'd2, 4, -1, 32'h700);
        send_pkt(48'h0000_0000_0004, 8'h01, 8'hFF, 16'd3, 3, -1, 32'h800);
        drain("length");

        // header truncated on word1, then good packet; len=0 packet
        send_pkt(48'hDEAD_BEEF_0001, 8'h01, 8'h01, 16'd3, 0, 1, 32'h0);
        send_pkt(48'hDEAD_BEEF_0002, 8'h01, 8'h01, 16'd1, 1, -1, 32'h900);
        send_pkt(48'hDEAD_BEEF_0003, 8'h01, 8'h01, 16'd0, 0, -1, 32'h0);
        drain("hdrerr");

        // asynchronous reset while a payload word is held
        rdy_mode = 2;
        send_pkt(48'h5555_0000_0001, 8'h01, 8'h01, 16'd3, 1, -1, 32'hA00);
        repeat (2) @(posedge clk_i);
        #1;
        chk("pre_rst_mvld", m_axis_tvalid, 1);
        #3;
        rst_i = 1'b1;
        #1;
        chk("arst_mvld", m_axis_tvalid, 0);
        chk("arst_mdat", m_axis_tdata, 0);
        chk("arst_hdr", hdr_o, 0);
        chk("arst_pkt", pkt_cnt_o, 0);
        chk("arst_drop", drop_cnt_o, 0);
        chk("arst_tready", s_axis_tready, 0);
        exp_q.delete();
        hdr_q.delete();
        exp_pkt = 0; exp_drop = 0; exp_hdr = 0; exp_short = 0; exp_long = 0;
        n_hdr = 0; n_short = 0; n_long = 0;
        rdy_mode = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        send_pkt(48'h6666_0000_0002, 8'h01, 8'h01, 16'd2, 2, -1, 32'hB00);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
